op_sum_multicycle: RTL and testbench

//  Parametrised N-bit adder evaluated W bits per clock with a start/busy/done handshake.

---
 rtl/op_sum_pkg.sv | 19 +
 rtl/op_sum_chunk.sv | 30 +++
 rtl/op_sum_multicycle.sv | 130 +++++++++++++
 tb/tb_op_sum_multicycle.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/op_sum_pkg.sv
// Shared definitions for the multicycle chunked adder.
// Build option: define OP_SUM_SUB_EN to add the subtract request port on the top.
package op_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } op_sum_state_t;

    localparam int OP_SUM_N_DEF = 8;
    localparam int OP_SUM_W_DEF = 4;

    // Width of the chunk counter: enough bits to index C chunks, never less than one.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/op_sum_chunk.sv
// Combinational W-bit adder slice with carry in/out.
// Also exports the carry into its MSB so the top can form the signed-overflow flag.
module sum_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    if (W == 1) begin : g_single_bit
        // The only bit is the MSB, so the carry into it is the chunk carry-in.
        assign c_msb = cin;
        assign sum   = a ^ b ^ cin;
    end else begin : g_multi_bit
        logic [W-1:0] low_sum;

        // Add the bits below the MSB; the top bit of this result is the carry into the MSB.
        assign low_sum = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, cin};
        assign c_msb   = low_sum[W-1];
        assign sum     = {a[W-1] ^ b[W-1] ^ c_msb, low_sum[W-2:0]};
    end

    // Carry out of the MSB is the majority of its two operand bits and incoming carry.
    assign cout = (a[W-1] & b[W-1]) | ((a[W-1] ^ b[W-1]) & c_msb);

endmodule

// File: rtl/op_sum_multicycle.sv
// N-bit adder evaluated W bits per clock (C = N/W chunks, LSB chunk first)
// with a start/busy/done handshake and registered sum, carry-out and overflow.
// Build option: OP_SUM_SUB_EN adds input 'sub' (1 = A - B).
module op_sum_multicycle
    import op_sum_pkg::*;
#(
    parameter int N = OP_SUM_N_DEF,
    parameter int W = OP_SUM_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         c_in,
`ifdef OP_SUM_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Z,
    output logic         c_out,
    output logic         ovf
);

    localparam int C  = N / W;
    localparam int CW = cnt_width(C);
    localparam logic [CW-1:0] LAST_CNT = CW'(C - 1);

    if ((W <= 0) || (N % W != 0)) begin : g_bad_width
        $error("op_sum_multicycle: N (%0d) must be a positive multiple of W (%0d)", N, W);
    end

    op_sum_state_t  state_q, state_d;
    logic [N-1:0]   a_q, b_q, z_q;
    logic           carry_q, c_out_q, ovf_q;
    logic [CW-1:0]  cnt_q;

    logic           accept, last_chunk;
    logic [N-1:0]   b_load;
    logic           carry_load;
    logic [W-1:0]   a_chunk, b_chunk, chunk_sum;
    logic           chunk_cout, chunk_c_msb;

    // A request is taken in any state except while chunks are still being summed.
    assign accept     = start && (state_q != CALC);
    assign last_chunk = (cnt_q == LAST_CNT);

`ifdef OP_SUM_SUB_EN
    // Subtraction is A + ~B + 1; the caller's carry-in is ignored in that case.
    assign b_load     = sub ? ~B : B;
    assign carry_load = sub ? 1'b1 : c_in;
`else
    assign b_load     = B;
    assign carry_load = c_in;
`endif

    // Select the current chunk of each captured operand for the single adder slice.
    assign a_chunk = a_q[cnt_q*W +: W];
    assign b_chunk = b_q[cnt_q*W +: W];

    sum_chunk #(.W(W)) u_sum_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> CALC -> DONE -> IDLE, with back-to-back restart from DONE.
    // NOTE: state_d gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last_chunk) state_d = DONE;
            DONE:    state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on accept, then one chunk summed per clock while in CALC.
    // NOTE: operand and result registers are few flops, so they take the async reset too,
    //       which keeps Z/c_out/ovf at zero out of reset without extra gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= A;
            b_q     <= b_load;
            carry_q <= carry_load;
            z_q     <= '0;
            cnt_q   <= '0;
        end else if (state_q == CALC) begin
            z_q[cnt_q*W +: W] <= chunk_sum;
            carry_q           <= chunk_cout;
            if (last_chunk) begin
                c_out_q <= chunk_cout;
                ovf_q   <= chunk_c_msb ^ chunk_cout;
                cnt_q   <= '0;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    assign busy  = (state_q == CALC);
    assign done  = (state_q == DONE);
    assign Z     = z_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_op_sum_multicycle.sv
// Scoreboard bench for op_sum_multicycle (N=8, W=4): the driver pushes reference
// results into a queue, the monitor pops and compares on every done pulse.
// Build option: OP_SUM_SUB_EN also exercises subtraction.
module tb_op_sum_multicycle;

    localparam int N = 8;
    localparam int W = 4;
    localparam int C = N / W;

    typedef struct packed {
        logic [N-1:0] z;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] A, B;
    logic         c_in;
    logic         sub;
    logic         busy, done, c_out, ovf;
    logic [N-1:0] Z;

    int n_vec;
    int n_fail;
    exp_t exp_q[$];

    op_sum_multicycle #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .c_in  (c_in),
`ifdef OP_SUM_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Z     (Z),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as unsigned and signed numbers.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic cin, input logic s);
        exp_t e;
        int ua, ub, ur, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ur  = ua - ub;
            sr  = sa - sb;
            e.c = (ua >= ub);
        end else begin
            ur  = ua + ub + int'(cin);
            sr  = sa + sb + int'(cin);
            e.c = (ur > (1 << N) - 1);
        end
        e.z = ur[N-1:0];
        e.o = (sr > (1 << (N-1)) - 1) || (sr < -(1 << (N-1)));
        return e;
    endfunction

    // Present a request and queue its expected result.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic s);
        A     = a;
        B     = b;
        c_in  = cin;
        sub   = s;
        start = 1'b1;
        exp_q.push_back(model(a, b, cin, s));
    endtask

    // Called #1 after the accept edge: checks busy just before done, and done exactly C edges later.
    task automatic wait_done();
        bit seen = 0;
        for (int k = 1; k <= C + 6 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (k == C - 1) check("busy_before_done", {31'b0, busy}, 32'd1);
            if (done) begin
                seen = 1;
                check("done_latency", k, C);
                check("busy_with_done", {31'b0, busy}, 32'd0);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic cin, input logic s);
        drive(a, b, cin, s);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("Z",     {24'b0, Z},      {24'b0, e.z});
                check("c_out", {31'b0, c_out},  {31'b0, e.c});
                check("ovf",   {31'b0, ovf},    {31'b0, e.o});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        c_in   = 1'b0;
        sub    = 1'b0;
        #23;
        check("rst_busy",  {31'b0, busy},  32'd0);
        check("rst_done",  {31'b0, done},  32'd0);
        check("rst_Z",     {24'b0, Z},     32'd0);
        check("rst_c_out", {31'b0, c_out}, 32'd0);
        check("rst_ovf",   {31'b0, ovf},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed additions: inter-chunk carry, wrap with carry-out, signed overflow.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h2A, 8'h5A, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // start held through CALC with changed operands is ignored; restart from DONE is accepted.
        drive(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        A    = 8'h55;
        B    = 8'h66;
        c_in = 1'b1;
        wait_done();
        exp_q.push_back(model(8'h55, 8'h66, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

`ifdef OP_SUM_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, 1'b1);
        run_op(8'h07, 8'h07, 1'b0, 1'b1);
`endif

        // Leave non-zero flags behind, then abort a calculation with reset.
        run_op(8'h7F, 8'h81, 1'b1, 1'b0);
        A     = 8'h34;
        B     = 8'h12;
        c_in  = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  {31'b0, busy},  32'd0);
        check("abort_done",  {31'b0, done},  32'd0);
        check("abort_Z",     {24'b0, Z},     32'd0);
        check("abort_c_out", {31'b0, c_out}, 32'd0);
        check("abort_ovf",   {31'b0, ovf},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_no_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        run_op(8'h34, 8'h12, 1'b1, 1'b0);

        // Random operations with random idle gaps (gap 0 exercises back-to-back starts).
        for (int n = 0; n < 1000; n++) begin
            logic [N-1:0] ra, rb;
            logic         rc, rs;
            int           gap;
            ra  = N'($urandom);
            rb  = N'($urandom);
            rc  = 1'($urandom);
`ifdef OP_SUM_SUB_EN
            rs  = 1'($urandom);
`else
            rs  = 1'b0;
`endif
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(posedge clk);
            #1;
            run_op(ra, rb, rc, rs);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
